// File: rtl/scarv_rng_lfsr_pool.sv
// Galois-LFSR randomness source for the scarv-cpu rng_* port, buffered through a small sample FIFO.
// Optional repetition health test enabled by defining SCARV_RNG_LFSR_POOL_REPTEST_EN.
module scarv_rng_lfsr_pool #(
    parameter int                 LFSR_W      = 64,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS   = 64'hD800000000000000,
    parameter logic [LFSR_W-1:0]  RESET_VALUE = 64'hABCDEF3713579BDF,
    parameter int                 FIFO_DEPTH  = 4,
    parameter int                 REP_LIMIT   = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        rng_req_valid,
    input  logic [2:0]  rng_req_op,
    input  logic [31:0] rng_req_data,
    output logic        rng_req_ready,
    output logic        rng_rsp_valid,
    output logic [2:0]  rng_rsp_status,
    output logic [31:0] rng_rsp_data,
    input  logic        rng_rsp_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_NO_INIT   = 3'b000,
        ST_UNHEALTHY = 3'b100,
        ST_HEALTHY   = 3'b101
    } status_t;

    if (LFSR_W < 32) begin : g_bad_width
        $error("LFSR_W must be at least 32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (REP_LIMIT < 1) begin : g_bad_rep
        $error("REP_LIMIT must be at least 1");
    end

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    logic [LFSR_W-1:0] state;
    logic              seeded;
    logic              unhealthy;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    status_t           rsp_status_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_valid_q;

    status_t           status;
    status_t           rsp_status_d;
    logic [31:0]       rsp_data_d;
    logic              accept, op_seed, op_samp, op_test;
    logic              healthy, fifo_empty, fifo_full;
    logic              pop, push, bypass;
    logic [LFSR_W-1:0] state_step;
    logic [LFSR_W-1:0] seed_state;

    assign status = !seeded ? ST_NO_INIT : (unhealthy ? ST_UNHEALTHY : ST_HEALTHY);
    assign healthy    = (status == ST_HEALTHY);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));

    assign rng_req_ready = !rsp_valid_q || rng_rsp_ready;
    assign accept  = rng_req_valid && rng_req_ready;
    assign op_seed = accept && (rng_req_op == 3'b001);
    assign op_samp = accept && (rng_req_op == 3'b010);
    assign op_test = accept && (rng_req_op == 3'b100);

    assign state_step = lfsr_step(state);
    assign seed_state = state_step ^ LFSR_W'(rng_req_data);

    // An empty FIFO is bypassed on SAMP: the live state is returned and the fill pauses one cycle.
    assign pop    = op_samp && healthy && !fifo_empty;
    assign bypass = op_samp && healthy && fifo_empty;
    assign push   = healthy && !op_seed && !bypass && (!fifo_full || pop);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rsp_data_d   = '0;
        rsp_status_d = status;
        if (op_seed)
            rsp_status_d = (seed_state == '0) ? ST_UNHEALTHY : ST_HEALTHY;
        else if (pop)
            rsp_data_d = mem[rd_ptr];
        else if (bypass)
            rsp_data_d = state[31:0];
        else if (op_test)
            rsp_data_d = 32'(count);
    end

`ifdef SCARV_RNG_LFSR_POOL_REPTEST_EN
    logic [31:0]                   last_sample;
    logic [$clog2(REP_LIMIT+1):0]  rep_cnt;
    logic [$clog2(REP_LIMIT+1):0]  rep_next;

    assign rep_next = (rep_cnt != '0 && state[31:0] == last_sample) ? rep_cnt + 1'b1 : 1;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state        <= RESET_VALUE;
            seeded       <= 1'b0;
            unhealthy    <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_NO_INIT;
`ifdef SCARV_RNG_LFSR_POOL_REPTEST_EN
            last_sample  <= '0;
            rep_cnt      <= '0;
`endif
        end else begin
            if (op_seed) begin
                state     <= seed_state;
                seeded    <= 1'b1;
                unhealthy <= (seed_state == '0);
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
`ifdef SCARV_RNG_LFSR_POOL_REPTEST_EN
                rep_cnt   <= '0;
`endif
            end else begin
                if (push || bypass)
                    state <= state_step;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
`ifdef SCARV_RNG_LFSR_POOL_REPTEST_EN
                if (push) begin
                    last_sample <= state[31:0];
                    rep_cnt     <= (rep_next > REP_LIMIT) ? rep_cnt : rep_next;
                    if (rep_next >= REP_LIMIT)
                        unhealthy <= 1'b1;
                end
`endif
            end

            if (accept) begin
                rsp_valid_q  <= 1'b1;
                rsp_data_q   <= rsp_data_d;
                rsp_status_q <= rsp_status_d;
            end else if (rng_rsp_ready) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    // NOTE: the sample storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge g_clk) begin
        if (push)
            mem[wr_ptr] <= state[31:0];
    end

    assign rng_rsp_valid  = rsp_valid_q;
    assign rng_rsp_data   = rsp_data_q;
    assign rng_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_scarv_rng_lfsr_pool.sv
// Randomised bench for scarv_rng_lfsr_pool against a queue-based reference model,
// plus directed checks on zero-state locking (32-bit instance) and a zero reset value.
module tb_scarv_rng_lfsr_pool;

    localparam logic [63:0] TAPS  = 64'hD800000000000000;
    localparam logic [63:0] RSTV  = 64'hABCDEF3713579BDF;
    localparam int          DEPTH = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        rng_req_valid;
    logic [2:0]  rng_req_op;
    logic [31:0] rng_req_data;
    logic        rng_rsp_ready;

    logic        rng_req_ready, rng_rsp_valid;
    logic [2:0]  rng_rsp_status;
    logic [31:0] rng_rsp_data;
    logic        w_req_ready, w_rsp_valid;
    logic [2:0]  w_rsp_status;
    logic [31:0] w_rsp_data;
    logic        z_req_ready, z_rsp_valid;
    logic [2:0]  z_rsp_status;
    logic [31:0] z_rsp_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 g_clk = ~g_clk;

    scarv_rng_lfsr_pool dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .rng_req_valid(rng_req_valid), .rng_req_op(rng_req_op), .rng_req_data(rng_req_data),
        .rng_req_ready(rng_req_ready), .rng_rsp_valid(rng_rsp_valid),
        .rng_rsp_status(rng_rsp_status), .rng_rsp_data(rng_rsp_data),
        .rng_rsp_ready(rng_rsp_ready)
    );

    scarv_rng_lfsr_pool #(.LFSR_W(32), .LFSR_TAPS(32'h80200003), .RESET_VALUE(32'h2)) dut_w32 (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .rng_req_valid(rng_req_valid), .rng_req_op(rng_req_op), .rng_req_data(rng_req_data),
        .rng_req_ready(w_req_ready), .rng_rsp_valid(w_rsp_valid),
        .rng_rsp_status(w_rsp_status), .rng_rsp_data(w_rsp_data),
        .rng_rsp_ready(rng_rsp_ready)
    );

    scarv_rng_lfsr_pool #(.RESET_VALUE(64'h0)) dut_zero (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .rng_req_valid(rng_req_valid), .rng_req_op(rng_req_op), .rng_req_data(rng_req_data),
        .rng_req_ready(z_req_ready), .rng_rsp_valid(z_rsp_valid),
        .rng_rsp_status(z_rsp_status), .rng_rsp_data(z_rsp_data),
        .rng_rsp_ready(rng_rsp_ready)
    );

    // Reference model: abstract LFSR value, a sample queue and the expected response register.
    logic [63:0] m_state;
    logic [31:0] m_q [$];
    bit          m_seeded, m_unh;
    bit          m_rv;
    logic [31:0] m_rd;
    logic [2:0]  m_rs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 64'h0);
    endfunction

    function automatic logic [2:0] m_status();
        if (!m_seeded) return 3'b000;
        return m_unh ? 3'b100 : 3'b101;
    endfunction

    task automatic model_reset();
        m_state = RSTV;
        m_q.delete();
        m_seeded = 0;
        m_unh = 0;
        m_rv = 0;
        m_rd = '0;
        m_rs = 3'b000;
    endtask

    task automatic model_tick(input bit v, input logic [2:0] op, input logic [31:0] d, input bit rr);
        logic [2:0]  st;
        logic [63:0] ns;
        bit          acc, gen_ok;
        st = m_status();
        acc = v && (!m_rv || rr);
        gen_ok = (st == 3'b101);
        if (acc) begin
            m_rv = 1;
            m_rs = st;
            m_rd = '0;
            if (op == 3'b001) begin
                ns = m_step(m_state) ^ {32'h0, d};
                m_state = ns;
                m_q.delete();
                m_seeded = 1;
                m_unh = (ns == 64'h0);
                m_rs = m_unh ? 3'b100 : 3'b101;
                gen_ok = 0;
            end else if (op == 3'b010 && st == 3'b101) begin
                if (m_q.size() > 0) begin
                    m_rd = m_q.pop_front();
                end else begin
                    m_rd = m_state[31:0];
                    m_state = m_step(m_state);
                    gen_ok = 0;
                end
            end else if (op == 3'b100) begin
                m_rd = 32'(m_q.size());
            end
        end else if (rr) begin
            m_rv = 0;
        end
        if (gen_ok && m_q.size() < DEPTH) begin
            m_q.push_back(m_state[31:0]);
            m_state = m_step(m_state);
        end
    endtask

    // One clock: drive inputs, check ready, advance model, check the registered response.
    task automatic do_cycle(input bit v, input logic [2:0] op, input logic [31:0] d, input bit rr);
        rng_req_valid = v;
        rng_req_op    = op;
        rng_req_data  = d;
        rng_rsp_ready = rr;
        #1;
        check("req_ready", rng_req_ready, !m_rv || rr);
        model_tick(v, op, d, rr);
        @(posedge g_clk);
        #1;
        check("rsp_valid", rng_rsp_valid, m_rv);
        if (m_rv) begin
            check("rsp_data", rng_rsp_data, m_rd);
            check("rsp_status", rng_rsp_status, m_rs);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 3'b000, 32'h0, 1);
    endtask

    initial begin
        logic [31:0] held_data;
        logic [2:0]  held_status;
        logic [2:0]  op;

        g_resetn = 1'b0;
        rng_req_valid = 0;
        rng_req_op = 3'b000;
        rng_req_data = '0;
        rng_rsp_ready = 1;
        model_reset();
        repeat (2) @(posedge g_clk);
        #3 g_resetn = 1'b1;

        check("reset_valid", rng_rsp_valid, 0);
        check("reset_status", rng_rsp_status, 3'b000);
        check("reset_data", rng_rsp_data, 0);

        do_cycle(1, 3'b100, 32'h0, 1);
        check("unseeded_test_status", rng_rsp_status, 3'b000);
        check("unseeded_test_data", rng_rsp_data, 0);
        do_cycle(1, 3'b010, 32'h0, 1);
        check("unseeded_samp_status", rng_rsp_status, 3'b000);
        check("unseeded_samp_data", rng_rsp_data, 0);

        do_cycle(1, 3'b001, 32'h1, 1);
        check("seed_status", rng_rsp_status, 3'b101);
        check("w32_zero_state_status", w_rsp_status, 3'b100);
        check("zero_rst_seed_status", z_rsp_status, 3'b101);
        idle(8);
        do_cycle(1, 3'b100, 32'h0, 1);
        check("fill_full_data", rng_rsp_data, 4);
        check("fill_full_status", rng_rsp_status, 3'b101);
        do_cycle(1, 3'b010, 32'h0, 1);
        check("zero_rst_samp0", z_rsp_data, 32'h1);
        check("w32_locked_samp_status", w_rsp_status, 3'b100);
        check("w32_locked_samp_data", w_rsp_data, 0);
        do_cycle(1, 3'b010, 32'h0, 1);
        check("zero_rst_samp1", z_rsp_data, 32'h0);
        do_cycle(1, 3'b001, 32'h5, 1);
        check("w32_reseed_status", w_rsp_status, 3'b101);

        // Back-pressure: response must hold while the CPU is not ready.
        idle(6);
        do_cycle(1, 3'b010, 32'h0, 0);
        held_data = rng_rsp_data;
        held_status = rng_rsp_status;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 3'b100, 32'h0, 0);
            check("stall_req_ready", rng_req_ready, 0);
            check("stall_data", rng_rsp_data, held_data);
            check("stall_status", rng_rsp_status, held_status);
        end
        do_cycle(0, 3'b000, 32'h0, 1);
        do_cycle(1, 3'b100, 32'h0, 1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       op = 3'b001;
                1, 2, 3: op = 3'b010;
                4, 5:    op = 3'b100;
                6:       op = 3'($urandom);
                default: op = 3'b010;
            endcase
            do_cycle($urandom_range(0, 3) != 0, op, $urandom, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a pending response.
        idle(2);
        do_cycle(1, 3'b010, 32'h0, 0);
        #2 g_resetn = 1'b0;
        #1;
        model_reset();
        check("async_rst_valid", rng_rsp_valid, 0);
        check("async_rst_status", rng_rsp_status, 3'b000);
        @(posedge g_clk);
        #3 g_resetn = 1'b1;
        do_cycle(1, 3'b100, 32'h0, 1);
        check("post_rst_fifo_empty", rng_rsp_data, 0);
        check("post_rst_status", rng_rsp_status, 3'b000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
